// File: rtl/mem_stage.sv
// Memory access pipeline stage.
// Issues at most one data-memory request per load/store instruction and holds
// the pipeline until that request completes. Misaligned or illegal accesses are
// dropped and flagged. Every other instruction passes its result straight to
// the MEM->WB register.
module mem_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] ex_alu_result,
   input  logic [31:0] ex_write_data,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic        ex_reg_write,
   input  logic [4:0]  ex_rd,
   input  logic [2:0]  ex_funct3,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic [3:0]  dm_be,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic        stall_mem,
   output logic [31:0] bp_mem,
   output logic [31:0] wb_result,
   output logic [4:0]  wb_rd,
   output logic        wb_reg_write,
   output logic        misalign_err
);

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   // Fields captured when the access is accepted. They stay stable for the whole BUSY phase.
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [2:0]  r_funct3;
   logic [4:0]  r_rd;
   logic        r_reg_write;
   logic        r_is_load;

   logic        w_access;
   logic        w_is_load;
   logic        w_size_ok;
   logic        w_align_ok;
   logic        w_legal;
   logic        w_fire;
   logic        w_bad;
   logic        w_done;

   // Replicate the store operand across the lanes so that any byte lane carries the data.
   function automatic logic [31:0] f_store_data(input logic [2:0] f3, input logic [31:0] d);
      case (f3[1:0])
         2'b00:   f_store_data = {4{d[7:0]}};
         2'b01:   f_store_data = {2{d[15:0]}};
         default: f_store_data = d;
      endcase
   endfunction

   // Build the byte enables for a store from its size and address lane.
   function automatic logic [3:0] f_store_be(input logic [2:0] f3, input logic [1:0] lane);
      case (f3[1:0])
         2'b00:   f_store_be = 4'b0001 << lane;
         2'b01:   f_store_be = 4'b0011 << lane;
         default: f_store_be = 4'b1111;
      endcase
   endfunction

   // Extract the addressed byte or halfword from the read word, then sign- or zero-extend it.
   function automatic logic [31:0] f_load_fmt(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] rd);
      logic [31:0] sh;
      sh = rd >> {lane, 3'b000};
      case (f3)
         3'b000:  f_load_fmt = {{24{sh[7]}}, sh[7:0]};
         3'b001:  f_load_fmt = {{16{sh[15]}}, sh[15:0]};
         3'b100:  f_load_fmt = {24'h0, sh[7:0]};
         3'b101:  f_load_fmt = {16'h0, sh[15:0]};
         default: f_load_fmt = rd;
      endcase
   endfunction

   // Classify the instruction in EX: whether it is an access, and whether that access is legal.
   always_comb begin
      w_access  = ex_mem_read | ex_mem_write;
      w_is_load = ex_mem_read;
      if (w_is_load)
         w_size_ok = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010) ||
                     (ex_funct3 == 3'b100) || (ex_funct3 == 3'b101);
      else
         w_size_ok = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010);
      case (ex_funct3[1:0])
         2'b01:   w_align_ok = ~ex_alu_result[0];
         2'b10:   w_align_ok = (ex_alu_result[1:0] == 2'b00);
         default: w_align_ok = 1'b1;
      endcase
      w_legal = w_size_ok & w_align_ok;
      w_fire  = (r_state == S_IDLE) & w_access & w_legal;
      w_bad   = (r_state == S_IDLE) & w_access & ~w_legal;
      w_done  = (r_state == S_BUSY) & dm_ack;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state: accept a legal access in IDLE, and return to IDLE on acknowledge.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_fire) w_state_nxt = S_BUSY;
         S_BUSY:  if (dm_ack) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Capture the request fields only when an access is accepted. They are never re-sampled while BUSY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr      <= 32'h0;
         r_wdata     <= 32'h0;
         r_funct3    <= 3'h0;
         r_rd        <= 5'h0;
         r_reg_write <= 1'b0;
         r_is_load   <= 1'b0;
      end else if (w_fire) begin
         r_addr      <= ex_alu_result;
         r_wdata     <= ex_write_data;
         r_funct3    <= ex_funct3;
         r_rd        <= ex_rd;
         r_reg_write <= ex_reg_write;
         r_is_load   <= w_is_load;
      end
   end

   // MEM->WB payload and the one-cycle misalignment flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_result    <= 32'h0;
         wb_rd        <= 5'h0;
         wb_reg_write <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         misalign_err <= w_bad;
         if (r_state == S_IDLE) begin
            if (!w_access) begin
               wb_result    <= ex_alu_result;
               wb_rd        <= ex_rd;
               wb_reg_write <= ex_reg_write;
            end else begin
               wb_reg_write <= 1'b0;
            end
         end else if (w_done) begin
            if (r_is_load) begin
               wb_result    <= f_load_fmt(r_funct3, r_addr[1:0], dm_rdata);
               wb_rd        <= r_rd;
               wb_reg_write <= r_reg_write;
            end else begin
               wb_reg_write <= 1'b0;
            end
         end else begin
            wb_reg_write <= 1'b0;
         end
      end
   end

   // Memory request and stall outputs. Reset masks the stall even while EX presents an access.
   always_comb begin
      dm_req    = (r_state == S_BUSY);
      dm_we     = dm_req & ~r_is_load;
      dm_addr   = {r_addr[31:2], 2'b00};
      dm_wdata  = r_is_load ? 32'h0 : f_store_data(r_funct3, r_wdata);
      dm_be     = 4'b0000;
      if (dm_req) dm_be = r_is_load ? 4'b1111 : f_store_be(r_funct3, r_addr[1:0]);
      stall_mem = rst_n & ((r_state == S_IDLE) ? w_fire : ~dm_ack);
      bp_mem    = ex_alu_result;
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads, stores, misaligned
// and illegal accesses, reset while BUSY, and back-to-back memory operations.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] ex_alu_result, ex_write_data, dm_rdata;
   logic        ex_mem_read, ex_mem_write, ex_reg_write, dm_ack;
   logic [4:0]  ex_rd;
   logic [2:0]  ex_funct3;
   logic        dm_req, dm_we, stall_mem, wb_reg_write, misalign_err;
   logic [31:0] dm_addr, dm_wdata, bp_mem, wb_result;
   logic [3:0]  dm_be;
   logic [4:0]  wb_rd;

   int n_chk  = 0;
   int n_pass = 0;
   int hs_cnt = 0;
   int hs_base;
   int stall_cnt;

   mem_stage dut (
      .clk(clk), .rst_n(rst_n),
      .ex_alu_result(ex_alu_result), .ex_write_data(ex_write_data),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
      .ex_rd(ex_rd), .ex_funct3(ex_funct3),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .stall_mem(stall_mem), .bp_mem(bp_mem),
      .wb_result(wb_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
      .misalign_err(misalign_err)
   );

   always #5 clk = ~clk;

   // Count completed memory handshakes.
   always @(posedge clk) if (dm_req && dm_ack) hs_cnt <= hs_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_ex(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                         input logic [2:0] f3, input logic rw, input logic mr, input logic mw);
      ex_alu_result = alu; ex_write_data = wd; ex_rd = rd; ex_funct3 = f3;
      ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw;
   endtask

   initial begin
      rst_n = 1'b0; dm_ack = 1'b0; dm_rdata = 32'h0;
      // A legal load is presented during reset: the stall must still be masked.
      set_ex(32'h40, 32'h0, 5'd1, 3'b010, 1'b1, 1'b1, 1'b0);
      repeat (3) tick();
      chk("rst_stall", stall_mem, 0);
      chk("rst_req", dm_req, 0);
      chk("rst_wb_result", wb_result, 0);
      chk("rst_wb_rd", wb_rd, 0);
      chk("rst_wb_rw", wb_reg_write, 0);
      chk("rst_misalign", misalign_err, 0);
      set_ex(0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;

      // ALU operation: one cycle.
      tick();
      set_ex(32'h1234, 0, 5'd5, 3'b000, 1'b1, 1'b0, 1'b0); #1;
      chk("alu_stall", stall_mem, 0);
      chk("alu_bp", bp_mem, 32'h1234);
      tick();
      set_ex(0, 0, 0, 0, 0, 0, 0); #1;
      chk("alu_wb_result", wb_result, 32'h1234);
      chk("alu_wb_rd", wb_rd, 5);
      chk("alu_wb_rw", wb_reg_write, 1);

      // LB at 0x103; the ack arrives after three BUSY cycles.
      tick();
      set_ex(32'h103, 0, 5'd7, 3'b000, 1'b1, 1'b1, 1'b0); #1;
      stall_cnt = int'(stall_mem);
      chk("lb_idle_req", dm_req, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 3) begin dm_ack = 1'b1; dm_rdata = 32'h80FF_FF7F; end
         #1;
         stall_cnt += int'(stall_mem);
         chk("lb_busy_req", dm_req, 1);
      end
      chk("lb_addr", dm_addr, 32'h100);
      chk("lb_we", dm_we, 0);
      chk("lb_be", dm_be, 4'b1111);
      chk("lb_stall_cycles", stall_cnt, 4);
      tick();
      dm_ack = 1'b0; set_ex(0, 0, 0, 0, 0, 0, 0); #1;
      chk("lb_result", wb_result, 32'hFFFF_FF80);
      chk("lb_rd", wb_rd, 7);
      chk("lb_rw", wb_reg_write, 1);
      chk("lb_no_reissue", dm_req, 0);

      // SH of 0xBEEF at 0x202, acknowledged on the first BUSY cycle.
      tick();
      set_ex(32'h202, 32'h0000_BEEF, 5'd8, 3'b001, 1'b1, 1'b0, 1'b1); #1;
      chk("sh_idle_stall", stall_mem, 1);
      tick();
      dm_ack = 1'b1; #1;
      chk("sh_we", dm_we, 1);
      chk("sh_addr", dm_addr, 32'h200);
      chk("sh_wdata", dm_wdata, 32'hBEEF_BEEF);
      chk("sh_be", dm_be, 4'b1100);
      chk("sh_ack_stall", stall_mem, 0);
      tick();
      dm_ack = 1'b0; set_ex(0, 0, 0, 0, 0, 0, 0); #1;
      chk("sh_wb_rw", wb_reg_write, 0);
      chk("sh_req_drop", dm_req, 0);

      // SB of 0xAB at 0x101.
      tick();
      set_ex(32'h101, 32'h1234_56AB, 5'd0, 3'b000, 1'b0, 1'b0, 1'b1);
      tick();
      dm_ack = 1'b1; #1;
      chk("sb_wdata", dm_wdata, 32'hABAB_ABAB);
      chk("sb_be", dm_be, 4'b0010);
      tick();
      dm_ack = 1'b0;

      // LHU at 0x302.
      set_ex(32'h302, 0, 5'd11, 3'b101, 1'b1, 1'b1, 1'b0);
      tick();
      dm_ack = 1'b1; dm_rdata = 32'h8001_2345;
      tick();
      dm_ack = 1'b0; set_ex(0, 0, 0, 0, 0, 0, 0); #1;
      chk("lhu_result", wb_result, 32'h0000_8001);

      // Misaligned LW at 0x6.
      tick();
      set_ex(32'h6, 0, 5'd4, 3'b010, 1'b1, 1'b1, 1'b0); #1;
      chk("mis_stall", stall_mem, 0);
      tick();
      set_ex(0, 0, 0, 0, 0, 0, 0); #1;
      chk("mis_err", misalign_err, 1);
      chk("mis_req", dm_req, 0);
      chk("mis_wb_rw", wb_reg_write, 0);
      tick();
      chk("mis_err_pulse", misalign_err, 0);

      // Store with an illegal funct3 is dropped and flagged.
      set_ex(32'h8, 32'h5, 5'd0, 3'b100, 1'b0, 1'b0, 1'b1); #1;
      chk("ill_stall", stall_mem, 0);
      tick();
      set_ex(0, 0, 0, 0, 0, 0, 0); #1;
      chk("ill_err", misalign_err, 1);
      chk("ill_req", dm_req, 0);

      // Reset asserted while BUSY abandons the request.
      tick();
      set_ex(32'h40, 0, 5'd2, 3'b010, 1'b1, 1'b1, 1'b0);
      tick();
      chk("rb_busy_req", dm_req, 1);
      rst_n = 1'b0; #1;
      chk("rb_req_drop", dm_req, 0);
      chk("rb_stall_drop", stall_mem, 0);
      set_ex(0, 0, 0, 0, 0, 0, 0);
      dm_ack = 1'b1; dm_rdata = 32'hDEAD_BEEF;
      tick();
      rst_n = 1'b1;
      tick(); #1;
      chk("rb_ack_ignored_req", dm_req, 0);
      chk("rb_ack_ignored_rw", wb_reg_write, 0);
      set_ex(32'hABCD, 0, 5'd3, 3'b000, 1'b1, 1'b0, 1'b0);
      tick();
      dm_ack = 1'b0; set_ex(0, 0, 0, 0, 0, 0, 0); #1;
      chk("rb_alu_result", wb_result, 32'hABCD);
      chk("rb_alu_rw", wb_reg_write, 1);

      // Back-to-back LW then SW, each acknowledged on the first BUSY cycle.
      hs_base = hs_cnt;
      tick();
      set_ex(32'h10, 0, 5'd9, 3'b010, 1'b1, 1'b1, 1'b0); #1;
      chk("bb_c1_stall", stall_mem, 1);
      tick();
      dm_ack = 1'b1; dm_rdata = 32'h1122_3344; #1;
      chk("bb_c2_stall", stall_mem, 0);
      tick();
      dm_ack = 1'b0;
      set_ex(32'h14, 32'hCAFE_F00D, 5'd0, 3'b010, 1'b0, 1'b0, 1'b1); #1;
      chk("bb_c3_req", dm_req, 0);
      chk("bb_c3_stall", stall_mem, 1);
      chk("bb_lw_result", wb_result, 32'h1122_3344);
      chk("bb_lw_rd", wb_rd, 9);
      tick();
      dm_ack = 1'b1; #1;
      chk("bb_sw_we", dm_we, 1);
      chk("bb_sw_addr", dm_addr, 32'h14);
      chk("bb_sw_wdata", dm_wdata, 32'hCAFE_F00D);
      chk("bb_sw_be", dm_be, 4'b1111);
      tick();
      dm_ack = 1'b0; set_ex(0, 0, 0, 0, 0, 0, 0); #1;
      chk("bb_end_req", dm_req, 0);
      chk("bb_end_rw", wb_reg_write, 0);
      chk("bb_handshakes", hs_cnt - hs_base, 2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on posedge clk.
REQ-002 rst_n  input  1  reset; asynchronous and active-low.
REQ-003 ex_alu_result  input  32  effective address or ALU result from the execute pipeline register.
REQ-004 ex_write_data  input  32  store data (rs2 value).
REQ-005 ex_mem_read / ex_mem_write / ex_reg_write  input  1 each  already flush/valid-qualified controls.
REQ-006 ex_rd  input  5; ex_funct3  input  3  destination register; access size/sign.
REQ-007 dm_req  output  1; dm_we  output  1; dm_addr  output  32 (bits [1:0] always 0); dm_wdata  output  32; dm_be  output  4  data-memory request.
REQ-008 dm_ack  input  1; dm_rdata  input  32  memory completion and read word, valid while dm_ack=1.
REQ-009 stall_mem  output  1  hold execute register and upstream stages.
REQ-010 bp_mem  output  32  forwarding value to execute.
REQ-011 wb_result  output  32; wb_rd  output  5; wb_reg_write  output  1  registered MEM->WB payload.
REQ-012 misalign_err  output  1  one-cycle registered pulse for an illegal or misaligned access.

Function
REQ-013 States: IDLE, BUSY; reset state IDLE.
REQ-014 access = ex_mem_read | ex_mem_write (read takes priority if both set); legal = funct3 in {000,001,010,100,101} for loads, {000,001,010} for stores, and aligned (half: addr[0]=0; word: addr[1:0]=0).
REQ-015 IDLE, no access: next edge wb_result<=ex_alu_result, wb_rd<=ex_rd, wb_reg_write<=ex_reg_write; stall_mem=0.
REQ-016 IDLE, access and legal: stall_mem=1 combinationally; next edge latch addr/data/funct3/rd/reg_write/type, state->BUSY, wb_reg_write<=0.
REQ-017 IDLE, access and not legal: no dm_req, stall_mem=0; next edge misalign_err<=1, wb_reg_write<=0.
REQ-018 BUSY: dm_req=1 with stable latched fields until dm_ack; stall_mem = ~dm_ack.
REQ-019 BUSY and dm_ack: next edge state->IDLE; load: wb_result<=formatted rdata, wb_reg_write<=latched reg_write; store: wb_reg_write<=0.
REQ-020 The ex_* inputs are not re-sampled in the dm_ack cycle; this prevents double issue.
REQ-021 Minimum memory-op latency: 2 cycles (ack on first BUSY cycle); non-memory ops: 1 cycle.
REQ-022 Load format uses lane addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough.
REQ-023 Store: SB replicates byte x4, dm_be=0001<<addr[1:0]; SH replicates half x2, dm_be=0011<<addr[1:0]; SW dm_be=1111.
REQ-024 Loads: dm_we=0, dm_be=1111. dm_req=0 in IDLE; dm_ack is ignored in IDLE.
REQ-025 bp_mem = ex_alu_result combinationally; load data is not forwarded from this stage.
REQ-026 misalign_err is high for exactly one cycle per offending instruction.

Reset
REQ-027 rst_n low forces immediately: state IDLE, dm_req=0, stall_mem=0, misalign_err=0, wb_reg_write=0, wb_result=0, wb_rd=0, latched fields 0.
REQ-028 Reset asserted in BUSY abandons the request; a dm_ack arriving after reset release while in IDLE has no effect.

Verification
REQ-029 ALU op: ex_alu_result=0x1234, ex_reg_write=1, rd=5 -> next cycle wb_result=0x1234, wb_rd=5, wb_reg_write=1, stall_mem=0.
REQ-030 LB from addr 0x103 with rdata=0x80FF_FF7F, ack after 3 BUSY cycles -> dm_addr=0x100, stall_mem high 4 cycles, wb_result=0xFFFF_FF80.
REQ-031 SH of 0x0000_BEEF at 0x202 -> dm_we=1, dm_addr=0x200, dm_wdata=0xBEEF_BEEF, dm_be=1100; wb_reg_write=0.
REQ-032 LW at 0x0000_0006 -> no dm_req, misalign_err pulses 1 cycle, stall_mem=0.
REQ-033 rst_n low during BUSY -> dm_req and stall_mem drop immediately; after release, ack is ignored and the next ALU op completes in 1 cycle.
REQ-034 Back-to-back LW then SW, each with ack on first BUSY cycle -> exactly one dm_req handshake each, no duplicate access, 4 cycles total.
